// File: rtl/scratch_mem_arbiter.sv
// Round-robin, non-preemptive arbiter that lets NREQ requesters share one
// dual-port scratch memory (write port A, 1-cycle synchronous read port B).
module scratch_mem_arbiter #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          grant,
    input  logic [NREQ*ADDR_W-1:0]   reqReadAddr,
    input  logic [NREQ-1:0]          reqReadEn,
    input  logic [NREQ*ADDR_W-1:0]   reqWriteAddr,
    input  logic [NREQ*DATA_W-1:0]   reqWriteData,
    input  logic [NREQ-1:0]          reqWriteEn,
    output logic [ADDR_W-1:0]        memReadAddr,
    output logic [ADDR_W-1:0]        memWriteAddr,
    output logic [DATA_W-1:0]        memWriteData,
    output logic                     memWriteEn,
    input  logic [DATA_W-1:0]        memDataIn,
    output logic [DATA_W-1:0]        readData,
    output logic [NREQ-1:0]          readValid
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    state_e            state_q;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   read_valid_q;
    logic [IDX_W-1:0]  last_owner_q;

    logic [IDX_W-1:0]  rr_winner;
    logic              rr_found;
    logic [NREQ-1:0]   rr_onehot;
    logic              owner_held;
    int unsigned       rr_idx;

    // Round-robin search starting just after the last owner, wrapping to 0.
    always_comb begin
        rr_winner = '0;
        rr_found  = 1'b0;
        rr_idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            rr_idx = (32'(last_owner_q) + 32'd1 + k) % NREQ;
            if (!rr_found && req[IDX_W'(rr_idx)]) begin
                rr_found  = 1'b1;
                rr_winner = IDX_W'(rr_idx);
            end
        end
    end

    assign rr_onehot  = NREQ'(1) << rr_winner;
    assign owner_held = |(req & grant_q);

    // Arbitration FSM; the owner keeps the bus until it drops its own req.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            read_valid_q <= '0;
            last_owner_q <= IDX_W'(NREQ - 1);
        end else begin
            read_valid_q <= grant_q & reqReadEn;
            case (state_q)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant_q      <= rr_onehot;
                        last_owner_q <= rr_winner;
                        state_q      <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (!owner_held) begin
                        if (rr_found) begin
                            grant_q      <= rr_onehot;
                            last_owner_q <= rr_winner;
                        end else begin
                            grant_q <= '0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // AND-OR mux of the owner's memory signals; all zero while nobody owns the bus.
    logic [NREQ:0][ADDR_W-1:0] raddr_acc;
    logic [NREQ:0][ADDR_W-1:0] waddr_acc;
    logic [NREQ:0][DATA_W-1:0] wdata_acc;
    logic [NREQ:0]             wen_acc;

    assign raddr_acc[0] = '0;
    assign waddr_acc[0] = '0;
    assign wdata_acc[0] = '0;
    assign wen_acc[0]   = 1'b0;

    for (genvar g = 0; g < NREQ; g++) begin : g_mux
        assign raddr_acc[g+1] = raddr_acc[g]
                              | (reqReadAddr[g*ADDR_W +: ADDR_W] & {ADDR_W{grant_q[g]}});
        assign waddr_acc[g+1] = waddr_acc[g]
                              | (reqWriteAddr[g*ADDR_W +: ADDR_W] & {ADDR_W{grant_q[g]}});
        assign wdata_acc[g+1] = wdata_acc[g]
                              | (reqWriteData[g*DATA_W +: DATA_W] & {DATA_W{grant_q[g]}});
        assign wen_acc[g+1]   = wen_acc[g] | (reqWriteEn[g] & grant_q[g]);
    end

    assign memReadAddr  = raddr_acc[NREQ];
    assign memWriteAddr = waddr_acc[NREQ];
    assign memWriteData = wdata_acc[NREQ];
    assign memWriteEn   = wen_acc[NREQ];

    // Read data passes straight through; readValid tells each requester when it is theirs.
    assign readData  = memDataIn;
    assign grant     = grant_q;
    assign readValid = read_valid_q;

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Bench for scratch_mem_arbiter: behavioural owner/pointer model with a
// scoreboard memory, plus directed scenarios with literal expectations.
module tb_scratch_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      grant;
    logic [NREQ*AW-1:0]   reqReadAddr;
    logic [NREQ-1:0]      reqReadEn;
    logic [NREQ*AW-1:0]   reqWriteAddr;
    logic [NREQ*DW-1:0]   reqWriteData;
    logic [NREQ-1:0]      reqWriteEn;
    logic [AW-1:0]        memReadAddr;
    logic [AW-1:0]        memWriteAddr;
    logic [DW-1:0]        memWriteData;
    logic                 memWriteEn;
    logic [DW-1:0]        memDataIn = '0;
    logic [DW-1:0]        readData;
    logic [NREQ-1:0]      readValid;

    int n_pass  = 0;
    int n_total = 0;

    scratch_mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .grant        (grant),
        .reqReadAddr  (reqReadAddr),
        .reqReadEn    (reqReadEn),
        .reqWriteAddr (reqWriteAddr),
        .reqWriteData (reqWriteData),
        .reqWriteEn   (reqWriteEn),
        .memReadAddr  (memReadAddr),
        .memWriteAddr (memWriteAddr),
        .memWriteData (memWriteData),
        .memWriteEn   (memWriteEn),
        .memDataIn    (memDataIn),
        .readData     (readData),
        .readValid    (readValid)
    );

    always #5 clk = ~clk;

    // Read-first synchronous dual-port memory attached to the arbiter.
    logic [DW-1:0] ram [0:4095];
    always @(posedge clk) begin
        memDataIn <= ram[memReadAddr];
        if (memWriteEn === 1'b1) ram[memWriteAddr] <= memWriteData;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic bit_of(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic logic [AW-1:0] slice_a(input logic [NREQ*AW-1:0] v, input int i);
        return AW'(v >> (i * AW));
    endfunction

    function automatic logic [DW-1:0] slice_d(input logic [NREQ*DW-1:0] v, input int i);
        return DW'(v >> (i * DW));
    endfunction

    // Model: owner index (-1 = bus free), round-robin pointer, scoreboard memory.
    int              m_owner = -1;
    int              m_last  = NREQ - 1;
    bit              m_valid = 1'b0;
    logic [NREQ-1:0] m_rv    = '0;
    logic [DW-1:0]   m_rdata = '0;
    logic [DW-1:0]   m_mem [0:4095];

    always @(negedge clk) begin
        logic [NREQ-1:0] e_grant;
        logic [NREQ-1:0] nxt_rv;
        int              w;
        int              idx;
        if (m_valid) begin
            e_grant = (m_owner < 0) ? '0 : NREQ'(1 << m_owner);
            chk("grant", 64'(grant), 64'(e_grant));
            chk("readValid", 64'(readValid), 64'(m_rv));
            chk("memReadAddr", 64'(memReadAddr),
                64'((m_owner < 0) ? '0 : slice_a(reqReadAddr, m_owner)));
            chk("memWriteAddr", 64'(memWriteAddr),
                64'((m_owner < 0) ? '0 : slice_a(reqWriteAddr, m_owner)));
            chk("memWriteData", 64'(memWriteData),
                64'((m_owner < 0) ? '0 : slice_d(reqWriteData, m_owner)));
            chk("memWriteEn", 64'(memWriteEn),
                64'((m_owner < 0) ? 1'b0 : bit_of(reqWriteEn, m_owner)));
            if (m_rv != '0) chk("readData", 64'(readData), 64'(m_rdata));
        end
        nxt_rv = '0;
        if (m_owner >= 0 && bit_of(reqReadEn, m_owner)) begin
            nxt_rv  = NREQ'(1 << m_owner);
            m_rdata = m_mem[slice_a(reqReadAddr, m_owner)];
        end
        if (m_owner >= 0 && bit_of(reqWriteEn, m_owner))
            m_mem[slice_a(reqWriteAddr, m_owner)] = slice_d(reqWriteData, m_owner);
        if (reset) begin
            m_owner = -1;
            m_last  = NREQ - 1;
            m_rv    = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_rv = nxt_rv;
            if (!(m_owner >= 0 && bit_of(req, m_owner))) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_last + 1 + k) % NREQ;
                    if (w < 0 && bit_of(req, idx)) w = idx;
                end
                m_owner = w;
                if (w >= 0) m_last = w;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        req          = '0;
        reqReadAddr  = '0;
        reqReadEn    = '0;
        reqWriteAddr = '0;
        reqWriteData = '0;
        reqWriteEn   = '0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]   = 32'hA500_0000 | DW'(i);
            m_mem[i] = 32'hA500_0000 | DW'(i);
        end
        clear_all();
        reset = 1'b1;
        step();
        step();
        chk("rst_grant", 64'(grant), 64'(3'b000));
        chk("rst_readValid", 64'(readValid), 64'(3'b000));

        // Handover sequence with wrap to requester 0 first.
        reset = 1'b0;
        req   = 3'b111;
        step();
        chk("rr_grant0", 64'(grant), 64'(3'b001));
        step(); step(); step();
        chk("rr_hold0", 64'(grant), 64'(3'b001));
        req = 3'b110;
        step();
        chk("rr_grant1", 64'(grant), 64'(3'b010));
        req = 3'b100;
        step();
        chk("rr_grant2", 64'(grant), 64'(3'b100));
        req = 3'b000;
        step();
        chk("rr_idle", 64'(grant), 64'(3'b000));

        // Owner write wins over a non-owner writing the same address.
        req = 3'b010;
        step();
        chk("wr_grant1", 64'(grant), 64'(3'b010));
        req = 3'b110;
        reqWriteEn   = 3'b110;
        reqWriteAddr = {12'h0A5, 12'h0A5, 12'h000};
        reqWriteData = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0};
        #1;
        chk("wr_memData", 64'(memWriteData), 64'(32'hDEAD_BEEF));
        chk("wr_memEn", 64'(memWriteEn), 64'(1'b1));
        step();
        reqWriteEn  = 3'b000;
        reqReadEn   = 3'b010;
        reqReadAddr = {12'h0A5, 12'h0A5, 12'h000};
        step();
        chk("rd_valid", 64'(readValid), 64'(3'b010));
        chk("rd_data", 64'(readData), 64'(32'hDEAD_BEEF));
        // Same-cycle write and read to one address returns the old contents.
        reqWriteEn   = 3'b010;
        reqWriteData = {32'h0, 32'h1111_2222, 32'h0};
        step();
        chk("rfw_data", 64'(readData), 64'(32'hDEAD_BEEF));
        clear_all();
        req = 3'b100;
        step();
        chk("wr_handover2", 64'(grant), 64'(3'b100));
        req = 3'b000;
        step();

        // Lone requester 2 pulsing; bus outputs must be zero between bursts.
        reqReadAddr  = {12'h321, 12'h654, 12'h987};
        reqWriteAddr = {12'h111, 12'h222, 12'h333};
        reqWriteData = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        reqWriteEn   = 3'b000;
        for (int p = 0; p < 3; p++) begin
            req = 3'b100;
            step();
            chk("solo_grant", 64'(grant), 64'(3'b100));
            chk("solo_raddr", 64'(memReadAddr), 64'(12'h321));
            step();
            req = 3'b000;
            step();
            chk("solo_idle", 64'(grant), 64'(3'b000));
            chk("solo_zero", 64'({memReadAddr, memWriteAddr, memWriteData, memWriteEn}), 64'(0));
        end

        // Read in owner 0's final cycle is still delivered after handover.
        clear_all();
        req = 3'b011;
        step();
        chk("last_grant0", 64'(grant), 64'(3'b001));
        req       = 3'b010;
        reqReadEn = 3'b001;
        step();
        chk("last_grant1", 64'(grant), 64'(3'b010));
        chk("last_rvalid0", 64'(readValid), 64'(3'b001));

        // Reset mid-burst drops everything on the following cycle.
        reqReadEn  = 3'b010;
        reqWriteEn = 3'b010;
        reset      = 1'b1;
        step();
        chk("mrst_grant", 64'(grant), 64'(3'b000));
        chk("mrst_wen", 64'(memWriteEn), 64'(1'b0));
        chk("mrst_rvalid", 64'(readValid), 64'(3'b000));
        reset = 1'b0;
        req   = 3'b110;
        step();
        chk("mrst_regrant", 64'(grant), 64'(3'b010));

        // Pseudo-random traffic on a small address window, checked by the model.
        clear_all();
        for (int c = 0; c < 300; c++) begin
            if (c % 4 == 0) req = NREQ'($urandom);
            reqReadEn  = NREQ'($urandom);
            reqWriteEn = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                reqReadAddr[i*AW +: AW]  = AW'($urandom_range(0, 7));
                reqWriteAddr[i*AW +: AW] = AW'($urandom_range(0, 7));
                reqWriteData[i*DW +: DW] = $urandom;
            end
            reset = (c == 150);
            step();
        end
        reset = 1'b0;
        clear_all();
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scratch_mem_arbiter.md
SCRATCH_MEM_ARBITER -- requirements
Module: scratch_mem_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of requesters sharing one Scratch_Memory_Controller instance.
REQ-002 SHALL have parameter ADDR_W, default 12: scratch address width.
REQ-003 SHALL have parameter DATA_W, default 32: scratch data width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req, input, NREQ: request per requester; level, held for the whole access burst.
REQ-007 SHALL have port grant, output, NREQ: registered one-hot (or zero) grant.
REQ-008 SHALL have port reqReadAddr, input, NREQ*ADDR_W: per-requester read address; slice i at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port reqReadEn, input, NREQ: per-requester read strobe.
REQ-010 SHALL have port reqWriteAddr, input, NREQ*ADDR_W: per-requester write address.
REQ-011 SHALL have port reqWriteData, input, NREQ*DATA_W: per-requester write data.
REQ-012 SHALL have port reqWriteEn, input, NREQ: per-requester write enable.
REQ-013 SHALL have port memReadAddr, output, ADDR_W: to memory addrb.
REQ-014 SHALL have port memWriteAddr, output, ADDR_W: to memory addra.
REQ-015 SHALL have port memWriteData, output, DATA_W: to memory dina.
REQ-016 SHALL have port memWriteEn, output, 1: to memory wea.
REQ-017 SHALL have port memDataIn, input, DATA_W: from memory doutb (1-cycle synchronous read).
REQ-018 SHALL have port readData, output, DATA_W: memDataIn broadcast to all requesters.
REQ-019 SHALL have port readValid, output, NREQ: one-hot pulse marking readData valid for requester i.

Function
REQ-020 SHALL implement FSM with states IDLE (grant=0) and OWNED (exactly one grant bit set).
REQ-021 IDLE: if req!=0, SHALL select winner by round-robin starting at index (lastOwner+1) mod NREQ, set grant[winner] and lastOwner=winner at next edge, enter OWNED.
REQ-022 OWNED: while req[owner]=1, SHALL keep grant unchanged regardless of other requests (no preemption).
REQ-023 OWNED, req[owner]=0: SHALL re-arbitrate in that cycle over remaining req bits; winner granted at next edge (zero-dead-cycle handover); if none, return to IDLE with grant=0.
REQ-024 Arbitration latency SHALL be exactly 1 cycle from req rise (with bus free) to grant rise.
REQ-025 Memory port outputs SHALL be combinational muxes of the owner's signals selected by registered grant.
REQ-026 memWriteEn SHALL equal reqWriteEn[owner] AND grant[owner]; writes from non-owners SHALL be ignored.
REQ-027 With grant=0, memReadAddr, memWriteAddr, memWriteData SHALL be 0 and memWriteEn 0.
REQ-028 readValid[i] SHALL be registered: high one cycle after a cycle where grant[i]=1 and reqReadEn[i]=1, else 0.
REQ-029 A read issued in the last owned cycle SHALL still deliver readValid to that requester on the following cycle even if grant has moved.
REQ-030 Same-cycle write and read by owner to same address: readData SHALL return memory's pre-write value (memory read-first behaviour passed through unchanged).
REQ-031 lastOwner pointer SHALL wrap from NREQ-1 to 0.
REQ-032 req bits for indices >= NREQ do not exist; no X SHALL propagate to grant when req is all-zero.

Reset
REQ-033 On reset=1 at a clock edge: state=IDLE, grant=0, readValid=0, lastOwner=NREQ-1 (so requester 0 wins first).
REQ-034 Reset asserted mid-burst SHALL drop grant and memWriteEn to 0 on the following cycle; in-flight readValid SHALL be suppressed.
REQ-035 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-036 After reset, req=3'b111 at cycle 0 -> grant=3'b001 at cycle 1; drop req[0] at cycle 4 -> grant=3'b010 at cycle 5; drop req[1] -> grant=3'b100 next cycle.
REQ-037 Owner 1 writes 0xDEADBEEF to addr 0x0A5 while requester 2 drives writeEn with 0x12345678 to same addr -> only 0xDEADBEEF stored; owner 1 read of 0x0A5 next cycle -> readValid=3'b010, readData=0xDEADBEEF.
REQ-038 Single requester 2 alone, pulses req three times -> grant=3'b100 each time after 1-cycle latency; IDLE between bursts gives grant=0 and mem outputs all 0.
REQ-039 Owner 0 issues reqReadEn in its final cycle, requester 1 waiting -> grant=3'b010 and readValid=3'b001 on the same next cycle.
REQ-040 Reset asserted while grant=3'b010 with reqWriteEn[1]=1 and reqReadEn[1]=1 -> next cycle grant=0, memWriteEn=0, readValid=0; after release with req=3'b110 -> grant=3'b010.
